// File: rtl/fc_mac_lanes_if.sv
// rtl/fc_mac_lanes_if.sv - beat input and result output handshake bundle for fc_mac_lanes
interface fc_mac_lanes_if #(
    parameter int DW    = 16,
    parameter int LANES = 4
);
    logic                in_valid;
    logic                in_ready;
    logic                in_last;
    logic [LANES*DW-1:0] din;
    logic [LANES*DW-1:0] win;
    logic [DW-1:0]       bias;
    logic                relu_en;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       dout;

    modport master (
        output in_valid, in_last, din, win, bias, relu_en, out_ready,
        input  in_ready, out_valid, dout
    );

    modport slave (
        input  in_valid, in_last, din, win, bias, relu_en, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/fc_mac_lanes.sv
// rtl/fc_mac_lanes.sv - lane-parallel Q(QW) dot-product MAC with bias, rounding, saturation and ReLU
module fc_mac_lanes #(
    parameter int DW    = 16,
    parameter int QW    = 11,
    parameter int LANES = 4,
    parameter int GUARD = 8
) (
    input logic           clk,
    input logic           rst_n,
    fc_mac_lanes_if.slave bus
);
    localparam int PW   = 2 * DW;
    localparam int SW   = PW + $clog2(LANES);
    localparam int ACCW = SW + GUARD;
    localparam int RW   = ACCW - QW + 1;
    localparam logic signed [RW-1:0] SAT_HI = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_LO = ~SAT_HI;

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_OUT} state_t;

    state_t                  state_q, state_d;
    logic                    live_q, first_q, relu_q;
    logic [DW-1:0]           bias_q;
    logic                    accept, in_ready_c, out_valid_c;
    logic                    s1_valid, s1_last, s1_first;
    logic signed [PW-1:0]    prod_q [LANES];
    logic                    s2_valid, s2_last, s2_first;
    logic signed [SW-1:0]    sum_d, sum_q;
    logic signed [ACCW-1:0]  acc_q, bias_ext;
    logic                    acc_last_q, done_q;
    logic signed [RW-1:0]    acc_sh, rnd;
    logic                    carry;
    logic [DW-1:0]           res_d, dout_q;

    function automatic logic signed [PW-1:0] lane_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic signed [PW-1:0] ax, bx;
        ax = {{DW{a[DW-1]}}, a};
        bx = {{DW{b[DW-1]}}, b};
        return ax * bx;
    endfunction

    assign accept        = bus.in_valid & in_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.dout      = dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ACC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready_c = live_q;
                if (live_q && bus.in_valid && bus.in_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (done_q) state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = ST_ACC;
            end
            default: state_d = ST_ACC;
        endcase
    end

    // live_q keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q  <= 1'b0;
            first_q <= 1'b1;
            relu_q  <= 1'b0;
            bias_q  <= '0;
        end else begin
            live_q <= 1'b1;
            if (out_valid_c && bus.out_ready) first_q <= 1'b1;
            else if (accept)                  first_q <= 1'b0;
            if (accept && first_q) begin
                relu_q <= bus.relu_en;
                bias_q <= bus.bias;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_first <= 1'b0;
            for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
        end else begin
            s1_valid <= accept;
            s1_last  <= accept & bus.in_last;
            s1_first <= accept & first_q;
            if (accept)
                for (int i = 0; i < LANES; i++)
                    prod_q[i] <= lane_mul(bus.din[i*DW +: DW], bus.win[i*DW +: DW]);
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) sum_d = sum_d + SW'(prod_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_first <= 1'b0;
            sum_q    <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_first <= s1_first;
            if (s1_valid) sum_q <= sum_d;
        end
    end

    assign bias_ext = ACCW'($signed(bias_q)) <<< QW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            acc_last_q <= 1'b0;
        end else begin
            acc_last_q <= s2_valid & s2_last;
            if (s2_valid) acc_q <= (s2_first ? bias_ext : acc_q) + ACCW'(sum_q);
        end
    end

    // Negative ties need a nonzero tail below the half bit to round up, so they go away from zero
    always_comb begin
        acc_sh = RW'(acc_q >>> QW);
        carry  = acc_q[ACCW-1] ? (acc_q[QW-1] & (|acc_q[QW-2:0])) : acc_q[QW-1];
        rnd    = acc_sh + RW'({1'b0, carry});
        if (rnd > SAT_HI)      res_d = SAT_HI[DW-1:0];
        else if (rnd < SAT_LO) res_d = SAT_LO[DW-1:0];
        else                   res_d = rnd[DW-1:0];
        if (relu_q && res_d[DW-1]) res_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= acc_last_q;
            if (acc_last_q) dout_q <= res_d;
        end
    end
endmodule

// File: tb/tb_fc_mac_lanes.sv
// tb/tb_fc_mac_lanes.sv - directed self-checking bench for fc_mac_lanes
module tb_fc_mac_lanes;
    localparam int DW    = 16;
    localparam int QW    = 11;
    localparam int LANES = 4;
    localparam int GUARD = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fc_mac_lanes_if #(.DW(DW), .LANES(LANES)) bus ();

    fc_mac_lanes #(.DW(DW), .QW(QW), .LANES(LANES), .GUARD(GUARD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [LANES*DW-1:0] rep(input logic [DW-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [LANES*DW-1:0] lane0(input logic [DW-1:0] v);
        logic [LANES*DW-1:0] r;
        r = '0;
        r[DW-1:0] = v;
        return r;
    endfunction

    task automatic beat(input logic [LANES*DW-1:0] d, input logic [LANES*DW-1:0] w,
                        input logic [DW-1:0] b, input logic r, input logic l);
        int cnt = 0;
        bus.din      = d;
        bus.win      = w;
        bus.bias     = b;
        bus.relu_en  = r;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt == 20) check("beat_ready_timeout", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic result(input logic signed [31:0] exp, input string tag, input int hold);
        int cnt = 0;
        check({tag, "_drain_rdy"}, bus.in_ready, 0);
        while (bus.out_valid !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_lat"}, cnt, 4);
        check({tag, "_dout"}, $signed(bus.dout), exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, bus.out_valid, 1);
            check({tag, "_hold_dout"}, $signed(bus.dout), exp);
            check({tag, "_hold_rdy"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_post_rdy"}, bus.in_ready, 1);
        check({tag, "_post_valid"}, bus.out_valid, 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        clk          = 1'b0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.din      = '0;
        bus.win      = '0;
        bus.bias     = '0;
        bus.relu_en  = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_dout", $signed(bus.dout), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", bus.in_ready, 1);

        beat(rep(16'sd2048), rep(16'sd2048), 16'sd0, 1'b0, 1'b1);
        result(8192, "ones4", 0);

        beat(lane0(16'sd1), lane0(16'sd1024), 16'sd0, 1'b0, 1'b1);
        result(1, "rnd_pos_half", 0);
        beat(lane0(-16'sd1), lane0(16'sd1024), 16'sd0, 1'b0, 1'b1);
        result(-1, "rnd_neg_half", 0);
        beat(lane0(16'sd1), lane0(16'sd1023), 16'sd0, 1'b0, 1'b1);
        result(0, "rnd_pos_below", 0);
        beat(lane0(-16'sd1), lane0(16'sd1023), 16'sd0, 1'b0, 1'b1);
        result(0, "rnd_neg_below", 0);

        beat(rep(16'sd32767), rep(16'sd32767), 16'sd0, 1'b0, 1'b1);
        result(32767, "sat_hi", 0);
        beat(rep(16'sh8000), rep(16'sd32767), 16'sd0, 1'b0, 1'b1);
        result(-32768, "sat_lo", 0);
        beat(rep(16'sh8000), rep(16'sd32767), 16'sd0, 1'b1, 1'b1);
        result(0, "relu", 0);

        beat(lane0(16'sd2048), lane0(16'sd2048), 16'sd1024, 1'b0, 1'b0);
        @(negedge clk);
        beat(lane0(16'sd2048), lane0(16'sd2048), 16'sh7fff, 1'b0, 1'b0);
        beat(lane0(16'sd2048), lane0(16'sd2048), 16'sh7fff, 1'b0, 1'b1);
        result(7168, "multi_bias", 0);

        beat(lane0(16'sd2048), lane0(16'sd2048), 16'sd2048, 1'b0, 1'b1);
        result(4096, "bp", 5);
        beat(lane0(16'sd2048), lane0(16'sd2048), -16'sd1024, 1'b0, 1'b1);
        result(1024, "bias_reload", 0);

        beat(lane0(16'sd2048), lane0(16'sd2048), 16'sd0, 1'b0, 1'b0);
        beat(lane0(16'sd2048), lane0(16'sd2048), 16'sd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_dout", $signed(bus.dout), 0);
        check("midrst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rel_rdy", bus.in_ready, 1);
        beat(lane0(16'sd2048), lane0(16'sd2048), 16'sd0, 1'b0, 1'b1);
        result(2048, "after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fc_mac_lanes.md
# fc_mac_lanes

Parametrised fixed-point multiply-accumulate engine for the fully-connected layers. Each accepted beat carries LANES signed Q(QW) activation/weight pairs. The lane products are summed by a registered adder tree and accumulated over a vector of any length that ends with `in_last`. The result is then rounded half-away-from-zero back to Q(QW), saturated to DW bits, optionally passed through ReLU, and presented on a valid/ready output. It replaces per-element multipliers in the FC datapath with a lane-parallel dot-product unit, including bias injection.

## Interface
- `DW`, 16, data/weight/bias/result width (signed, two's complement)
- `QW`, 11, fractional bits of all operands and the result
- `LANES`, 4, parallel multiplier lanes (power of two, ≥1)
- `GUARD`, 8, accumulator guard bits; overflow-free for vectors up to 2^GUARD beats
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `in_valid` input 1: beat valid
- `in_ready` output 1: block accepts a beat this cycle
- `in_last` input 1: final beat of the vector
- `din` input LANES*DW: activations; lane i occupies bits [i*DW +: DW]
- `win` input LANES*DW: weights, same packing as `din`
- `bias` input DW: Q(QW) bias; sampled on the first beat of a vector only
- `relu_en` input 1: sampled on the first beat; clamps negative results to 0
- `out_valid` output 1: result valid
- `out_ready` input 1: downstream accepts the result
- `dout` output DW: Q(QW) result

## Operation
- Accept a beat when `in_valid & in_ready`.
- First beat of a vector: the first accepted beat after reset or after the previous result handshake.
- Widths:
  - product is 2*DW bits, Q(2*QW)
  - tree sum is 2*DW + log2(LANES) bits
  - accumulator ACCW = 2*DW + log2(LANES) + GUARD bits, Q(2*QW), wraps modulo 2^ACCW
- Pipeline, one stage per cycle:
  - S1 registers all lane products.
  - S2 registers the adder-tree sum.
  - S3 accumulates. On a first beat: acc = sign_extend(bias) << QW, plus the sum. Otherwise acc = acc + sum.
  - S4 runs only for the last beat: round, saturate, ReLU, then registers `dout` and sets `out_valid`.
- Rounding (carry into bit QW of acc):
  - acc ≥ 0: carry = acc[QW-1].
  - acc < 0: carry = acc[QW-1] & |acc[QW-2:0].
  - r = (acc >>> QW) + carry, i.e. ties round away from zero.
- Saturation: if r > 2^(DW-1)-1, output 2^(DW-1)-1. If r < -2^(DW-1), output -2^(DW-1). Otherwise output r[DW-1:0].
- ReLU: if `relu_en` was latched and the saturated result is negative, output 0.
- FSM states:
  - ACC: `in_ready`=1. Accepting a beat with `in_last` moves to DRAIN.
  - DRAIN: `in_ready`=0. Waits for the last beat to exit S4, then moves to OUT.
  - OUT: `out_valid`=1, `in_ready`=0. On `out_ready`, moves to ACC and arms first-beat.
- Gaps: `in_valid` gaps mid-vector insert bubbles; accumulation resumes with no state loss.
- Single-beat vector: first and last beat at once. Bias and sum are combined in S3.
- While `out_valid`=1 and `out_ready`=0, `dout` is held stable.
- Reset asserted at any time: pipeline, accumulator and FSM are cleared. The partial vector is discarded with no output.

## Timing
- Reset values: `in_ready`=0 while `rst_n`=0 and 1 from the first edge after release; `out_valid`=0; `dout`=0; state ACC; first-beat armed.
- Latency: last beat accepted at edge N → `out_valid`=1 after edge N+4.
- Throughput: one beat per cycle inside a vector. After `in_last`, `in_ready` stays low until the cycle after the result handshake.
- The result handshake completes at the edge where `out_valid & out_ready`. `in_ready` rises in the following cycle.
- `in_ready` does not depend combinationally on `in_valid`. `out_valid` does not depend on `out_ready`.

## Test plan
- DW=16, QW=11, LANES=4, all lanes `din`=`win`=2048, `bias`=0, single last beat → `dout`=8192 (4.0), `out_valid` 4 cycles after acceptance.
- Rounding: lane0 `win`=1024, `din`=1, other lanes 0 → `dout`=1. With `din`=-1 → `dout`=-1. With `win`=1023, `din`=±1 → 0.
- Saturation and ReLU: all lanes 32767×32767 → 32767. `din`=-32768, `win`=32767 → -32768. Same with `relu_en`=1 → 0.
- Multi-beat with bias: 3 beats (lane0 2048×2048, others 0), `bias`=1024, `in_valid` low one cycle between beats 1 and 2 → `dout`=7168 (3.5).
- Backpressure: `out_ready` low 5 cycles → `out_valid` held, `dout` stable, `in_ready`=0. After the handshake, the next vector's first beat reloads bias.
- Reset mid-vector after 2 beats → `out_valid`=0, `dout`=0. A following single-beat vector gives only its own result.
